aucohl_tmr32_apb: RTL and testbench

//  32-bit prescaled timer/PWM peripheral on an APB slave port. Counts up, down or up/down

---
 rtl/aucohl_tmr32_pkg.sv | 56 +++++
 rtl/aucohl_tmr32_core.sv | 128 ++++++++++++
 rtl/aucohl_tmr32_apb.sv | 145 ++++++++++++++
 tb/tb_aucohl_tmr32_apb.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aucohl_tmr32_pkg.sv
// Shared definitions for the aucohl 32-bit timer/PWM peripheral:
// register offsets, direction and PWM action encodings, status bits.
package aucohl_tmr32_pkg;

    localparam logic [15:0] A_TMR    = 16'h0000;
    localparam logic [15:0] A_RELOAD = 16'h0004;
    localparam logic [15:0] A_PR     = 16'h0008;
    localparam logic [15:0] A_CMPX   = 16'h000C;
    localparam logic [15:0] A_CMPY   = 16'h0010;
    localparam logic [15:0] A_CTRL   = 16'h0014;
    localparam logic [15:0] A_CFG    = 16'h0018;
    localparam logic [15:0] A_PWM0   = 16'h001C;
    localparam logic [15:0] A_PWM1   = 16'h0020;
    localparam logic [15:0] A_IM     = 16'hFF00;
    localparam logic [15:0] A_MIS    = 16'hFF04;
    localparam logic [15:0] A_RIS    = 16'hFF08;
    localparam logic [15:0] A_IC     = 16'hFF0C;

    typedef enum logic [1:0] {
        DIR_HALT = 2'b00,
        DIR_DOWN = 2'b01,
        DIR_UP   = 2'b10,
        DIR_UPDN = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ACT_NONE = 2'b00,
        ACT_LOW  = 2'b01,
        ACT_HIGH = 2'b10,
        ACT_TOG  = 2'b11
    } act_e;

    localparam int RIS_TO = 0;
    localparam int RIS_MX = 1;
    localparam int RIS_MY = 2;

    // Later events overwrite earlier ones, so the highest index wins.
    function automatic logic pwm_next(input logic st,
                                      input logic [11:0] cfg,
                                      input logic [5:0] ev);
        logic r;
        r = st;
        for (int i = 0; i < 6; i++) begin
            if (ev[i]) begin
                case (act_e'(cfg[2*i +: 2]))
                    ACT_LOW:  r = 1'b0;
                    ACT_HIGH: r = 1'b1;
                    ACT_TOG:  r = ~st;
                    default:  ;
                endcase
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aucohl_tmr32_core.sv
// Timer core: prescaler, up/down/up-down counter, match events
// and the two PWM state bits driven by event actions.
module aucohl_tmr32_core
    import aucohl_tmr32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        te,
    input  logic        ts,
    input  dir_e        dir,
    input  logic        periodic,
    input  logic [31:0] reload,
    input  logic [15:0] pr,
    input  logic [31:0] cmpx,
    input  logic [31:0] cmpy,
    input  logic [11:0] pwm0_cfg,
    input  logic [11:0] pwm1_cfg,
    output logic [31:0] count,
    output logic        timeout_flag,
    output logic        mx,
    output logic        my,
    output logic        pwm0_state,
    output logic        pwm1_state
);

    logic [15:0] pre_cnt;
    logic        tick;
    logic        done;
    logic        ud_down;
    logic        ud_down_n;
    logic        step_down;
    logic        wrap;
    logic        advance;
    logic [31:0] nxt;
    logic [5:0]  ev;

    assign tick = te & ~ts & (pre_cnt == pr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre_cnt <= '0;
        else if (!te || ts || tick)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 16'd1;
    end

    always_comb begin
        nxt       = count;
        ud_down_n = ud_down;
        step_down = 1'b0;
        wrap      = 1'b0;
        case (dir)
            DIR_UP: begin
                if (count >= reload) begin
                    nxt  = '0;
                    wrap = 1'b1;
                end else begin
                    nxt = count + 32'd1;
                end
            end
            DIR_DOWN: begin
                step_down = 1'b1;
                if (count == '0) begin
                    nxt  = reload;
                    wrap = 1'b1;
                end else begin
                    nxt = count - 32'd1;
                end
            end
            DIR_UPDN: begin
                // The step off the top is already a down step.
                if (ud_down && count != '0) begin
                    step_down = 1'b1;
                    nxt       = count - 32'd1;
                end else if (count >= reload) begin
                    step_down = (reload != '0);
                    nxt       = (reload == '0) ? '0 : reload - 32'd1;
                end else begin
                    nxt = count + 32'd1;
                end
                ud_down_n = step_down && (nxt != '0);
                wrap      = (nxt == '0);
            end
            default: ;
        endcase
    end

    assign advance      = tick & ~done & (dir != DIR_HALT);
    assign timeout_flag = advance & wrap;
    assign mx           = advance & (nxt == cmpx);
    assign my           = advance & (nxt == cmpy);

    assign ev = advance ? {(nxt == cmpx) &  step_down,
                           (nxt == cmpy) &  step_down,
                           (nxt == reload),
                           (nxt == cmpy) & ~step_down,
                           (nxt == cmpx) & ~step_down,
                           (nxt == '0)} : 6'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            done    <= 1'b0;
            ud_down <= 1'b0;
        end else if (ts) begin
            count   <= (dir == DIR_DOWN) ? reload : '0;
            done    <= 1'b0;
            ud_down <= 1'b0;
        end else if (advance) begin
            count   <= nxt;
            ud_down <= ud_down_n;
            if (wrap && !periodic)
                done <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm0_state <= 1'b0;
            pwm1_state <= 1'b0;
        end else begin
            pwm0_state <= pwm_next(pwm0_state, pwm0_cfg, ev);
            pwm1_state <= pwm_next(pwm1_state, pwm1_cfg, ev);
        end
    end

endmodule

// File: rtl/aucohl_tmr32_apb.sv
// APB register file around the timer core; zero-wait-state slave,
// status readable only, PWM outputs gated by the fault input.
module aucohl_tmr32_apb
    import aucohl_tmr32_pkg::*;
(
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic [31:0] PADDR,
    input  logic        PWRITE,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        pwm0,
    output logic        pwm1,
    input  logic        pwm_fault
);

    logic [15:0] addr;
    logic        wr;
    logic        unused;
    logic [31:0] reload;
    logic [15:0] pr;
    logic [31:0] cmpx;
    logic [31:0] cmpy;
    logic        te, p0e, p1e, pi0, pi1;
    dir_e        dir;
    logic        periodic;
    logic [11:0] pwm0_cfg;
    logic [11:0] pwm1_cfg;
    logic [2:0]  im;
    logic [2:0]  ris;
    logic [2:0]  ris_set;
    logic [2:0]  ic;
    logic        ts;
    logic [31:0] count;
    logic        timeout_flag;
    logic        mx, my;
    logic        st0, st1;

    assign addr   = PADDR[15:0];
    assign unused = ^PADDR[31:16];
    assign wr     = PSEL & PENABLE & PWRITE;
    assign PREADY = 1'b1;
    assign ts     = wr & (addr == A_CTRL) & PWDATA[1];
    assign ic     = (wr && addr == A_IC) ? PWDATA[2:0] : 3'b0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            reload   <= '0;
            pr       <= '0;
            cmpx     <= '0;
            cmpy     <= '0;
            te       <= 1'b0;
            p0e      <= 1'b0;
            p1e      <= 1'b0;
            pi0      <= 1'b0;
            pi1      <= 1'b0;
            dir      <= DIR_HALT;
            periodic <= 1'b0;
            pwm0_cfg <= '0;
            pwm1_cfg <= '0;
            im       <= '0;
        end else if (wr) begin
            case (addr)
                A_RELOAD: reload <= PWDATA;
                A_PR:     pr     <= PWDATA[15:0];
                A_CMPX:   cmpx   <= PWDATA;
                A_CMPY:   cmpy   <= PWDATA;
                A_CTRL: begin
                    te  <= PWDATA[0];
                    p0e <= PWDATA[2];
                    p1e <= PWDATA[3];
                    pi0 <= PWDATA[4];
                    pi1 <= PWDATA[5];
                end
                A_CFG: begin
                    dir      <= dir_e'(PWDATA[1:0]);
                    periodic <= PWDATA[2];
                end
                A_PWM0:   pwm0_cfg <= PWDATA[11:0];
                A_PWM1:   pwm1_cfg <= PWDATA[11:0];
                A_IM:     im       <= PWDATA[2:0];
                default:  ;
            endcase
        end
    end

    assign ris_set[RIS_TO] = timeout_flag;
    assign ris_set[RIS_MX] = mx;
    assign ris_set[RIS_MY] = my;

    // A new event in the same cycle as a clear keeps its bit set.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            ris <= '0;
        else
            ris <= (ris & ~ic) | ris_set;
    end

    always_comb begin
        PRDATA = '0;
        case (addr)
            A_TMR:    PRDATA = count;
            A_RELOAD: PRDATA = reload;
            A_PR:     PRDATA = {16'b0, pr};
            A_CMPX:   PRDATA = cmpx;
            A_CMPY:   PRDATA = cmpy;
            A_CTRL:   PRDATA = {26'b0, pi1, pi0, p1e, p0e, 1'b0, te};
            A_CFG:    PRDATA = {29'b0, periodic, dir};
            A_PWM0:   PRDATA = {20'b0, pwm0_cfg};
            A_PWM1:   PRDATA = {20'b0, pwm1_cfg};
            A_IM:     PRDATA = {29'b0, im};
            A_MIS:    PRDATA = {29'b0, ris & im};
            A_RIS:    PRDATA = {29'b0, ris};
            default:  ;
        endcase
    end

    aucohl_tmr32_core u_core (
        .clk          (PCLK),
        .rst_n        (PRESETn),
        .te           (te),
        .ts           (ts),
        .dir          (dir),
        .periodic     (periodic),
        .reload       (reload),
        .pr           (pr),
        .cmpx         (cmpx),
        .cmpy         (cmpy),
        .pwm0_cfg     (pwm0_cfg),
        .pwm1_cfg     (pwm1_cfg),
        .count        (count),
        .timeout_flag (timeout_flag),
        .mx           (mx),
        .my           (my),
        .pwm0_state   (st0),
        .pwm1_state   (st1)
    );

    assign pwm0 = p0e & ~pwm_fault & (st0 ^ pi0);
    assign pwm1 = p1e & ~pwm_fault & (st1 ^ pi1);

endmodule

// File: tb/tb_aucohl_tmr32_apb.sv
// Scoreboard bench for aucohl_tmr32_apb: expected values are queued
// as stimulus is applied and popped when the DUT output is sampled.
module tb_aucohl_tmr32_apb;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [31:0] PADDR = '0;
    logic        PWRITE = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        pwm0, pwm1;
    logic        pwm_fault = 1'b0;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          wr_cyc = 0;
    int          t0 = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    logic [31:0] d;

    aucohl_tmr32_apb dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .pwm0      (pwm0),
        .pwm1      (pwm1),
        .pwm_fault (pwm_fault)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc++;

    task automatic apb_write(input logic [31:0] a, input logic [31:0] v);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = v; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        wr_cyc = cyc;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] v);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #3 v = PRDATA;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PADDR = '0;
    endtask

    task automatic test_reset();
        logic [31:0] ra [0:13];
        ra = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18,
               32'h1C, 32'h20, 32'hFF00, 32'hFF04, 32'hFF08, 32'hFF0C, 32'h40};
        PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(32'h0);
            PADDR = ra[i]; #1;
            e = exp_q.pop_front(); checks++;
            if (PRDATA !== e) begin
                failures++;
                $display("FAIL reset_read a=%h got %h want %h", ra[i], PRDATA, e);
            end
        end
        PADDR = '0;
        exp_q.push_back(32'h1);
        e = exp_q.pop_front(); checks++;
        if ({pwm1, pwm0, PREADY} !== e[2:0]) begin
            failures++;
            $display("FAIL reset_pins got %b want %b", {pwm1, pwm0, PREADY}, e[2:0]);
        end
        @(negedge PCLK); PRESETn = 1'b1;
    endtask

    task automatic test_regs();
        logic [31:0] wa [0:9];
        logic [31:0] wd [0:9];
        logic [31:0] we [0:9];
        wa = '{32'h04, 32'h08, 32'h14, 32'h18, 32'h20,
               32'h00, 32'hFF0C, 32'hFF00, 32'h40, 32'hFF04};
        wd = '{32'hDEADBEEF, 32'hFFFF1234, 32'h3E, 32'hFF, 32'hFFFFFFFF,
               32'h12345678, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7};
        we = '{32'hDEADBEEF, 32'h1234, 32'h3C, 32'h7, 32'hFFF,
               32'h0, 32'h0, 32'h7, 32'h0, 32'h0};
        for (int i = 0; i < 10; i++) begin
            apb_write(wa[i], wd[i]);
            exp_q.push_back(we[i]);
            apb_read(wa[i], d);
            e = exp_q.pop_front(); checks++;
            if (d !== e) begin
                failures++;
                $display("FAIL reg_rw a=%h got %h want %h", wa[i], d, e);
            end
        end
        apb_write(32'h14, 32'h0);
        apb_write(32'h18, 32'h0);
        apb_write(32'h20, 32'h0);
        apb_write(32'hFF00, 32'h0);
        apb_write(32'h04, 32'h0);
        apb_write(32'h08, 32'h0);
    endtask

    task automatic test_up_periodic();
        int n;
        apb_write(32'h04, 32'd9);
        apb_write(32'h08, 32'd0);
        apb_write(32'h18, 32'h6);
        apb_write(32'hFF0C, 32'h7);
        apb_write(32'h14, 32'h3);
        for (int k = 0; k < 25; k++) begin
            @(negedge PCLK);
            n = cyc - wr_cyc;
            exp_q.push_back(32'(n % 10));
            exp_q.push_back(32'(n % 10 == 9));
            e = exp_q.pop_front(); checks++;
            if (PRDATA !== e) begin
                failures++;
                $display("FAIL up_tmr n=%0d got %0d want %0d", n, PRDATA, e);
            end
            e = exp_q.pop_front(); checks++;
            if (dut.timeout_flag !== e[0]) begin
                failures++;
                $display("FAIL up_timeout n=%0d got %b want %b", n, dut.timeout_flag, e[0]);
            end
        end
        apb_write(32'h14, 32'h0);
        exp_q.push_back(32'h7);
        apb_read(32'hFF08, d);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin
            failures++;
            $display("FAIL up_ris got %h want %h", d, e);
        end
        apb_write(32'hFF0C, 32'h1);
        exp_q.push_back(32'h6);
        apb_read(32'hFF08, d);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin
            failures++;
            $display("FAIL up_ic got %h want %h", d, e);
        end
    endtask

    task automatic test_down_oneshot();
        int n;
        int pulses;
        pulses = 0;
        apb_write(32'h04, 32'd4);
        apb_write(32'h08, 32'd3);
        apb_write(32'h18, 32'h1);
        apb_write(32'hFF0C, 32'h7);
        apb_write(32'h14, 32'h3);
        for (int k = 0; k < 40; k++) begin
            @(negedge PCLK);
            n = cyc - wr_cyc;
            exp_q.push_back(n < 20 ? 32'(4 - n / 4) : 32'd4);
            e = exp_q.pop_front(); checks++;
            if (PRDATA !== e) begin
                failures++;
                $display("FAIL down_tmr n=%0d got %0d want %0d", n, PRDATA, e);
            end
            if (dut.timeout_flag) pulses++;
        end
        exp_q.push_back(32'd1);
        e = exp_q.pop_front(); checks++;
        if (32'(pulses) !== e) begin
            failures++;
            $display("FAIL down_oneshot_pulses got %0d want %0d", pulses, e);
        end
        exp_q.push_back(32'h7);
        apb_read(32'hFF08, d);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin
            failures++;
            $display("FAIL down_ris got %h want %h", d, e);
        end
        apb_write(32'h14, 32'h3);
        for (int k = 0; k < 10; k++) begin
            @(negedge PCLK);
            n = cyc - wr_cyc;
            exp_q.push_back(32'(4 - n / 4));
            e = exp_q.pop_front(); checks++;
            if (PRDATA !== e) begin
                failures++;
                $display("FAIL down_rerun n=%0d got %0d want %0d", n, PRDATA, e);
            end
        end
        apb_write(32'h14, 32'h0);
    endtask

    task automatic test_pwm();
        int n;
        apb_write(32'h04, 32'd9);
        apb_write(32'h08, 32'd0);
        apb_write(32'h0C, 32'd3);
        apb_write(32'h1C, 32'h006);
        apb_write(32'h20, 32'h081);
        apb_write(32'h18, 32'h6);
        apb_write(32'h14, 32'hF);
        t0 = wr_cyc;
        for (int k = 0; k < 40; k++) begin
            @(negedge PCLK);
            n = cyc - t0;
            if (n >= 10) begin
                exp_q.push_back({30'b0, n % 10 == 9, n % 10 < 3});
                e = exp_q.pop_front(); checks++;
                if ({pwm1, pwm0} !== e[1:0]) begin
                    failures++;
                    $display("FAIL pwm_pattern n=%0d got %b want %b", n, {pwm1, pwm0}, e[1:0]);
                end
            end
        end
        apb_write(32'h14, 32'h1D);
        for (int k = 0; k < 20; k++) begin
            @(negedge PCLK);
            n = cyc - t0;
            exp_q.push_back({30'b0, n % 10 == 9, !(n % 10 < 3)});
            e = exp_q.pop_front(); checks++;
            if ({pwm1, pwm0} !== e[1:0]) begin
                failures++;
                $display("FAIL pwm_invert n=%0d got %b want %b", n, {pwm1, pwm0}, e[1:0]);
            end
        end
    endtask

    task automatic test_fault();
        int n;
        logic f;
        for (int k = 0; k < 25; k++) begin
            @(negedge PCLK); #1;
            f = (k >= 5 && k < 15);
            pwm_fault = f;
            #1;
            n = cyc - t0;
            exp_q.push_back(f ? 32'h0 : {30'b0, n % 10 == 9, !(n % 10 < 3)});
            e = exp_q.pop_front(); checks++;
            if ({pwm1, pwm0} !== e[1:0]) begin
                failures++;
                $display("FAIL fault n=%0d f=%b got %b want %b", n, f, {pwm1, pwm0}, e[1:0]);
            end
        end
        pwm_fault = 1'b0;
        apb_write(32'h14, 32'h0);
    endtask

    task automatic test_updown();
        int n;
        int m;
        apb_write(32'h04, 32'd5);
        apb_write(32'h10, 32'd2);
        apb_write(32'h1C, 32'h120);
        apb_write(32'h20, 32'h0);
        apb_write(32'hFF00, 32'h4);
        apb_write(32'h18, 32'h7);
        apb_write(32'hFF0C, 32'h7);
        apb_write(32'h14, 32'h7);
        for (int k = 0; k < 30; k++) begin
            @(negedge PCLK);
            n = cyc - wr_cyc;
            m = n % 10;
            exp_q.push_back(32'(m <= 5 ? m : 10 - m));
            exp_q.push_back(32'(m == 9));
            e = exp_q.pop_front(); checks++;
            if (PRDATA !== e) begin
                failures++;
                $display("FAIL ud_tmr n=%0d got %0d want %0d", n, PRDATA, e);
            end
            e = exp_q.pop_front(); checks++;
            if (dut.timeout_flag !== e[0]) begin
                failures++;
                $display("FAIL ud_timeout n=%0d got %b want %b", n, dut.timeout_flag, e[0]);
            end
            if (n >= 10) begin
                exp_q.push_back(32'(m >= 2 && m <= 7));
                e = exp_q.pop_front(); checks++;
                if (pwm0 !== e[0]) begin
                    failures++;
                    $display("FAIL ud_cmpy_pwm n=%0d got %b want %b", n, pwm0, e[0]);
                end
            end
        end
        exp_q.push_back(32'h7);
        exp_q.push_back(32'h4);
        apb_read(32'hFF08, d);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin
            failures++;
            $display("FAIL ud_ris got %h want %h", d, e);
        end
        apb_read(32'hFF04, d);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin
            failures++;
            $display("FAIL ud_mis got %h want %h", d, e);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge PCLK); #1;
        PRESETn = 1'b0;
        #1;
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); checks++;
        if ({PRDATA[29:0], pwm1, pwm0} !== e) begin
            failures++;
            $display("FAIL reset_mid got %h/%b%b want 0", PRDATA, pwm1, pwm0);
        end
        PADDR = 32'h04; #1;
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); checks++;
        if (PRDATA !== e) begin
            failures++;
            $display("FAIL reset_mid_reload got %h want %h", PRDATA, e);
        end
        PADDR = '0;
        @(negedge PCLK); PRESETn = 1'b1;
    endtask

    task automatic test_reload_zero();
        apb_write(32'h18, 32'h6);
        apb_write(32'h14, 32'h3);
        for (int k = 0; k < 6; k++) begin
            @(negedge PCLK);
            exp_q.push_back({31'b0, 1'b1});
            e = exp_q.pop_front(); checks++;
            if ({PRDATA, dut.timeout_flag} !== {32'h0, e[0]}) begin
                failures++;
                $display("FAIL reload0 k=%0d got %h/%b want 0/%b", k, PRDATA, dut.timeout_flag, e[0]);
            end
        end
        apb_write(32'h14, 32'h0);
    endtask

    initial begin
        test_reset();
        test_regs();
        test_up_periodic();
        test_down_oneshot();
        test_pwm();
        test_fault();
        test_updown();
        test_reset_mid();
        test_reload_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
